// File: rtl/sync_reset_seq.sv
// sync_reset_seq: debounced, multi-domain reset controller.
// The push button asserts every domain reset asynchronously. Release happens
// synchronously to clk once the button has been stably high for a debounce
// window. Domains are released one at a time, bit 0 first, STAGGER cycles apart.
// In RUN, a single-cycle software request restarts the sequence with a shorter hold.
module sync_reset_seq #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 24000,
  parameter int SW_HOLD         = 16,
  parameter int NUM_DOMAINS     = 3,
  parameter int STAGGER         = 8
) (
  input  logic                   clk,
  input  logic                   key,
  input  logic                   sw_req,
  output logic [NUM_DOMAINS-1:0] reset,
  output logic                   done,
  output logic                   cause
);

  // The counter must hold the largest target without wrapping.
  localparam int CNT_MAX01 = (DEBOUNCE_CYCLES > SW_HOLD) ? DEBOUNCE_CYCLES : SW_HOLD;
  localparam int CNT_MAX   = (CNT_MAX01 > STAGGER) ? CNT_MAX01 : STAGGER;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] DEB_T = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] SWH_T = CNT_W'(SW_HOLD);
  localparam logic [CNT_W-1:0] STG_T = CNT_W'(STAGGER);

  typedef enum logic [1:0] {
    S_HOLD    = 2'd0,
    S_RELEASE = 2'd1,
    S_RUN     = 2'd2
  } state_t;

  state_t                   state_q;
  logic [SYNC_STAGES-1:0]   sync_q;
  logic [CNT_W-1:0]         cnt_q;
  logic [NUM_DOMAINS-1:0]   reset_q;
  logic                     done_q;
  logic                     cause_q;

  logic                     key_s;
  logic [CNT_W-1:0]         cnt_inc;
  logic [CNT_W-1:0]         hold_tgt;
  logic [NUM_DOMAINS-1:0]   reset_shift;

  assign key_s    = sync_q[SYNC_STAGES-1];
  assign cnt_inc  = cnt_q + CNT_W'(1);
  // A software-initiated sequence holds for SW_HOLD instead of the full debounce.
  assign hold_tgt = cause_q ? SWH_T : DEB_T;
  // Releasing the next domain keeps the thermometer code: clear the lowest set bit.
  assign reset_shift = reset_q << 1;

  // Synchroniser for the released key; a 1 ripples in while key stays high.
  always_ff @(posedge clk or negedge key) begin
    if (!key) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // Release sequencer: debounce/hold, staggered release, then run.
  always_ff @(posedge clk or negedge key) begin
    if (!key) begin
      state_q <= S_HOLD;
      cnt_q   <= '0;
      reset_q <= '1;
      done_q  <= 1'b0;
      cause_q <= 1'b0;
    end else begin
      case (state_q)
        S_HOLD: begin
          if (!key_s) begin
            cnt_q <= '0;
          end else if (cnt_inc == hold_tgt) begin
            cnt_q   <= '0;
            reset_q <= reset_shift;
            if (NUM_DOMAINS == 1) begin
              state_q <= S_RUN;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_RELEASE;
            end
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        S_RELEASE: begin
          if (cnt_inc == STG_T) begin
            cnt_q   <= '0;
            reset_q <= reset_shift;
            if (reset_shift == '0) begin
              state_q <= S_RUN;
              done_q  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        S_RUN: begin
          if (sw_req) begin
            reset_q <= '1;
            done_q  <= 1'b0;
            cause_q <= 1'b1;
            cnt_q   <= '0;
            state_q <= S_HOLD;
          end
        end
        default: begin
          state_q <= S_HOLD;
        end
      endcase
    end
  end

  assign reset = reset_q;
  assign done  = done_q;
  assign cause = cause_q;

endmodule
